sof_align_delay: RTL and testbench
==================================

# sof_align_delay

Aligns a video stream to a reference stream before the two are merged in the HDR datapath. It measures the clock-cycle skew between the source frame-start and the reference frame-start pulses. Once the skew is confirmed over consecutive frames, it programs an internal circular-buffer delay line so source pixels leave the block time-aligned to the reference stream. It sits in front of the exposure-merge stage, in the position a fixed-length shift-register delay would otherwise occupy.

## Interface
- `W`, 16: pixel data width.
- `AW`, 6: delay address width; buffer depth is 2**AW; legal delay is 1..2**AW-1.
- `LOCK_N`, 2: consecutive equal measurements required to lock (≥1).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `src_sof`  in  1  one-cycle frame-start pulse of the stream being delayed.
- `ref_sof`  in  1  one-cycle frame-start pulse of the reference stream.
- `data_in`  in  W  source pixel, sampled every cycle.
- `data_out`  out  W  delayed source pixel.
- `delay`  out  AW  delay currently applied, in cycles.
- `locked`  out  1  skew confirmed and applied.
- `err`  out  1  one-cycle pulse: measurement invalid (zero skew or timeout).

## Operation
- Reset values: `delay`=1, `locked`=0, `err`=0, `data_out`=0, FSM=IDLE, `cnt`=0, `cand`=0, `match`=0.
- Buffer RAM is not reset; `data_out` content is undefined for the first 2**AW cycles after reset.
- Delay line:
  - `wr_ptr` (AW bits) increments every cycle; `data_in` is written at `wr_ptr`.
  - Read is from `wr_ptr - delay` (mod 2**AW) into a registered `data_out`.
  - Net effect: `data_out` = `data_in` from exactly `delay` edges earlier.
- FSM states:
  - IDLE: `src_sof` without `ref_sof` → MEAS, `cnt`<=0. `src_sof` and `ref_sof` in the same cycle → `err` pulse, stay IDLE. `ref_sof` alone is ignored.
  - MEAS: `cnt` increments each cycle.
    - `ref_sof` with `cnt`=c → measurement M=c+1, → IDLE.
    - `ref_sof` has priority over a simultaneous `src_sof`; that `src_sof` is dropped.
    - `src_sof` without `ref_sof` → restart: `cnt`<=0, no error.
    - `cnt`=2**AW-2 and no `ref_sof` → timeout: `err` pulse, `locked`<=0, `match`<=0, → IDLE.
- Lock logic, evaluated on each valid M:
  - M==`cand`: `match`<=min(`match`+1, LOCK_N). If `match`+1 ≥ LOCK_N: `locked`<=1, `delay`<=M.
  - M!=`cand`: `cand`<=M, `match`<=1, `locked`<=0, `delay` held. If LOCK_N=1, instead lock immediately with `delay`<=M.
- `err` always clears `locked` and `match`; `delay` is held.
- A `delay` change takes effect on the next read. Samples may be repeated or skipped once; this is acceptable.
- `cnt` width is AW; it never wraps because of the timeout.

## Timing
- `locked`, `delay` and `err` update on the same edge that samples the terminating `ref_sof` (or the timeout/zero-skew condition). They are visible the following cycle.
- Skew definition: `src_sof` sampled at edge t0, `ref_sof` at edge t0+M → measured M.
- Data latency is exactly `delay` cycles: sample at edge t appears on `data_out` after edge t+`delay`.
- `rst` assertion at any time (including mid-MEAS) immediately forces all reset values. The first edge after deassertion is a normal IDLE cycle.
- Throughput: one pixel per cycle, no stalls, no backpressure.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `delay`=1, `locked`=0, `err`=0, `data_out`=0 immediately. After release, ramp `data_in` → `data_out` equals ramp delayed by 1.
- Lock at M=5, LOCK_N=2: two frames with `ref_sof` 5 cycles after `src_sof` → `locked`=0 after frame 1; `locked`=1 and `delay`=5 after frame 2. Ramp input → `data_out`(t)=`data_in`(t-5).
- Skew change 5→7 while locked: first M=7 frame → `locked`=0, `delay` stays 5. Second M=7 frame → `locked`=1, `delay`=7, output shift is 7.
- Timeout (AW=6): `src_sof`, then no `ref_sof` for 62 cycles → `err` high for exactly one cycle, `locked`=0, FSM back to IDLE. A subsequent M=3 frame measures correctly.
- Edge pulses:
  - `src_sof` and `ref_sof` in the same IDLE cycle → single `err` pulse.
  - `src_sof`, then a second `src_sof` 4 cycles later, then `ref_sof` 6 cycles after that → M=6, no `err`.
- Max skew: M=63 twice → `locked`=1, `delay`=63, `data_out` correct across `wr_ptr` wrap.

Source files
------------

// File: rtl/sof_align_delay.sv
`default_nettype none
// ============================================================================
// Module   : sof_align_delay
// Brief    : Measures the src_sof -> ref_sof skew in clock cycles. Once the
//            same skew has been seen on LOCK_N consecutive frames, it programs
//            a circular-buffer delay line so the source pixels leave the block
//            aligned to the reference stream.
// Revision : 1.0 - initial release
// ============================================================================
module sof_align_delay #(
  parameter int W      = 16,
  parameter int AW     = 6,
  parameter int LOCK_N = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          src_sof,
  input  logic          ref_sof,
  input  logic [W-1:0]  data_in,
  output logic [W-1:0]  data_out,
  output logic [AW-1:0] delay,
  output logic          locked,
  output logic          err
);

  // The match counter only has to hold values from 0 to LOCK_N.
  localparam int             MW      = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [AW-1:0]  CNT_MAX = AW'((2 ** AW) - 2);
  localparam logic [MW:0]    LOCK_NV = (MW + 1)'(LOCK_N);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MEAS = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   cand_q, cand_d;
  logic [AW-1:0]   delay_q, delay_d;
  logic [MW-1:0]   match_q, match_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_addr;
  logic [W-1:0]    data_out_q;
  logic [W-1:0]    mem_q [0:(2**AW)-1];

  // Result of the skew measurement, produced by the FSM for the lock logic.
  logic            meas_valid;
  logic            meas_err;
  logic [AW-1:0]   meas;
  logic [MW:0]     match_inc;

  // Skew-measurement FSM: next state, cycle counter and measurement events.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    meas_valid = 1'b0;
    meas_err   = 1'b0;
    // cnt counts from the cycle after src_sof, so skew is cnt + 1.
    meas       = cnt_q + AW'(1);
    case (state_q)
      S_IDLE: begin
        if (src_sof && ref_sof) begin
          meas_err = 1'b1;
        end else if (src_sof) begin
          state_d = S_MEAS;
          cnt_d   = '0;
        end
      end
      S_MEAS: begin
        if (ref_sof) begin
          // ref_sof wins over a coincident src_sof, which is dropped.
          meas_valid = 1'b1;
          state_d    = S_IDLE;
        end else if (src_sof) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          meas_err = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lock qualification: a skew must repeat LOCK_N times before it is applied.
  always_comb begin
    cand_d    = cand_q;
    match_d   = match_q;
    locked_d  = locked_q;
    delay_d   = delay_q;
    err_d     = 1'b0;
    match_inc = {1'b0, match_q} + (MW + 1)'(1);
    if (meas_err) begin
      err_d    = 1'b1;
      locked_d = 1'b0;
      match_d  = '0;
    end else if (meas_valid) begin
      if (meas == cand_q) begin
        match_d = (match_inc > LOCK_NV) ? LOCK_NV[MW-1:0] : match_inc[MW-1:0];
        if (match_inc >= LOCK_NV) begin
          locked_d = 1'b1;
          delay_d  = meas;
        end
      end else begin
        cand_d   = meas;
        match_d  = MW'(1);
        locked_d = 1'b0;
        if (LOCK_N == 1) begin
          locked_d = 1'b1;
          delay_d  = meas;
        end
      end
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      match_q  <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      delay_q  <= AW'(1);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      delay_q  <= delay_d;
    end
  end

  // Buffer RAM write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    mem_q[wr_ptr_q] <= data_in;
  end

  // Reading delay_q entries behind the write pointer gives exactly delay_q
  // cycles of latency through the registered output.
  assign rd_addr = wr_ptr_q - delay_q;

  // Write pointer and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + AW'(1);
      data_out_q <= mem_q[rd_addr];
    end
  end

  assign data_out = data_out_q;
  assign delay    = delay_q;
  assign locked   = locked_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sof_align_delay.sv
`default_nettype none
// ============================================================================
// Module   : tb_sof_align_delay
// Brief    : Self-checking bench for sof_align_delay: vector table, directed
//            corner sequences and randomized frames against a timestamp-based
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sof_align_delay;

  localparam int W      = 16;
  localparam int AW     = 6;
  localparam int LOCK_N = 2;
  localparam int TMO    = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          src_sof = 1'b0;
  logic          ref_sof = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  data_out;
  logic [AW-1:0] delay;
  logic          locked;
  logic          err;

  sof_align_delay #(.W(W), .AW(AW), .LOCK_N(LOCK_N)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_sof  (src_sof),
    .ref_sof  (ref_sof),
    .data_in  (data_in),
    .data_out (data_out),
    .delay    (delay),
    .locked   (locked),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: skew = difference of edge timestamps.
  int           m_delay, m_cand, m_match, e, t_src;
  bit           m_locked, m_err, m_active;
  logic [W-1:0] hist[$];
  bit           dv;
  logic [W-1:0] dexp;
  logic [W-1:0] ramp = '0;
  bit           rnd_data = 1'b0;
  int           err_seen = 0;

  typedef struct {
    bit src;
    bit rf;
    bit e_err;
    bit e_lk;
    int e_dly;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_delay = 1; m_cand = 0; m_match = 0;
    m_locked = 0; m_err = 0; m_active = 0;
    e = 0; t_src = 0;
    hist.delete();
  endtask

  task automatic model_measure(input int m);
    if (m == m_cand) begin
      if (m_match + 1 >= LOCK_N) begin
        m_locked = 1;
        m_delay  = m;
      end
      m_match = (m_match + 1 > LOCK_N) ? LOCK_N : m_match + 1;
    end else begin
      m_cand   = m;
      m_match  = 1;
      m_locked = 0;
      if (LOCK_N == 1) begin
        m_locked = 1;
        m_delay  = m;
      end
    end
  endtask

  task automatic model_error();
    m_err    = 1;
    m_locked = 0;
    m_match  = 0;
  endtask

  task automatic model_edge(input bit s, input bit r, input logic [W-1:0] d);
    int dprev;
    int m;
    dprev = m_delay;
    e++;
    hist.push_back(d);
    // Output after edge e is the sample from edge e - delay, if written since reset.
    dv = (e - dprev >= 1);
    if (dv) dexp = hist[e - dprev - 1];
    m_err = 0;
    if (!m_active) begin
      if (s && r) model_error();
      else if (s) begin
        m_active = 1;
        t_src    = e;
      end
    end else begin
      m = e - t_src;
      if (r) begin
        model_measure(m);
        m_active = 0;
      end else if (s) begin
        t_src = e;
      end else if (m >= TMO) begin
        model_error();
        m_active = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("delay", 32'(delay), 32'(m_delay));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("err", 32'(err), 32'(m_err));
    if (dv) chk("data_out", 32'(data_out), 32'(dexp));
    if (err === 1'b1) err_seen++;
  endtask

  task automatic step(input bit s, input bit r, input logic [W-1:0] d);
    src_sof = s;
    ref_sof = r;
    data_in = d;
    @(posedge clk);
    model_edge(s, r, d);
    #1;
    check_all();
  endtask

  task automatic stepr(input bit s, input bit r);
    logic [W-1:0] d;
    d = rnd_data ? W'($urandom) : ramp;
    ramp = ramp + W'(1);
    step(s, r, d);
  endtask

  task automatic frame(input int m, input int gap);
    stepr(1'b1, 1'b0);
    repeat (m - 1) stepr(1'b0, 1'b0);
    stepr(1'b0, 1'b1);
    repeat (gap) stepr(1'b0, 1'b0);
  endtask

  // Asserts rst mid-cycle and checks the outputs change without a clock edge.
  task automatic async_reset();
    src_sof = 1'b0;
    ref_sof = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_delay", 32'(delay), 32'd1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    // Lock at M=5 with LOCK_N=2, then hold.
    tbl[0]  = '{1, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 1};
    tbl[5]  = '{0, 1, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 1, 5};
    tbl[12] = '{0, 0, 0, 1, 5};
    tbl[13] = '{0, 0, 0, 1, 5};

    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("init_delay", 32'(delay), 32'd1);
    chk("init_locked", 32'(locked), 32'd0);
    chk("init_err", 32'(err), 32'd0);
    chk("init_data_out", 32'(data_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      stepr(tbl[i].src, tbl[i].rf);
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].e_lk));
      chk($sformatf("tbl%0d_delay", i), 32'(delay), 32'(tbl[i].e_dly));
    end
    repeat (10) stepr(1'b0, 1'b0);

    // Skew change 5 -> 7 while locked.
    frame(7, 2);
    chk("skew7a_locked", 32'(locked), 32'd0);
    chk("skew7a_delay", 32'(delay), 32'd5);
    frame(7, 2);
    chk("skew7b_locked", 32'(locked), 32'd1);
    chk("skew7b_delay", 32'(delay), 32'd7);
    repeat (12) stepr(1'b0, 1'b0);

    async_reset();
    repeat (10) stepr(1'b0, 1'b0);

    // Coincident pulses in IDLE.
    err_seen = 0;
    stepr(1'b1, 1'b1);
    chk("same_cycle_err", 32'(err), 32'd1);
    repeat (3) stepr(1'b0, 1'b0);
    chk("same_cycle_err_count", 32'(err_seen), 32'd1);

    // Restart on a second src_sof: skew is measured from the later one.
    err_seen = 0;
    for (int k = 0; k < 2; k++) begin
      stepr(1'b1, 1'b0);
      repeat (3) stepr(1'b0, 1'b0);
      stepr(1'b1, 1'b0);
      repeat (5) stepr(1'b0, 1'b0);
      stepr(1'b0, 1'b1);
      repeat (2) stepr(1'b0, 1'b0);
    end
    chk("restart_delay", 32'(delay), 32'd6);
    chk("restart_locked", 32'(locked), 32'd1);
    chk("restart_err_count", 32'(err_seen), 32'd0);

    // Timeout: err lands on the 63rd edge after src_sof, for one cycle.
    err_seen = 0;
    stepr(1'b1, 1'b0);
    repeat (62) stepr(1'b0, 1'b0);
    chk("timeout_early", 32'(err), 32'd0);
    stepr(1'b0, 1'b0);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_locked", 32'(locked), 32'd0);
    stepr(1'b0, 1'b0);
    chk("timeout_err_clear", 32'(err), 32'd0);
    chk("timeout_err_count", 32'(err_seen), 32'd1);
    frame(3, 2);
    frame(3, 2);
    chk("after_timeout_delay", 32'(delay), 32'd3);

    // Maximum skew and data across the pointer wrap.
    frame(63, 2);
    frame(63, 2);
    chk("max_locked", 32'(locked), 32'd1);
    chk("max_delay", 32'(delay), 32'd63);
    repeat (150) stepr(1'b0, 1'b0);

    // Randomized frames with repeated skews.
    rnd_data = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int m;
      m = int'($urandom_range(1, 63));
      repeat (int'($urandom_range(1, 3))) frame(m, int'($urandom_range(0, 8)));
      if (f == 20) async_reset();
    end
    // Fully random pulses.
    for (int c = 0; c < 800; c++) begin
      stepr(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
